// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync and debounce.
// Emits a one-cycle key_valid per accepted press with one-hot r/c.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1200,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_drv,
    output logic [3:0] r,
    output logic [3:0] c,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, sync2, cs;
    logic [1:0]    idx, idx_n;
    logic [1:0]    cap_row, cap_row_n;
    logic [3:0]    cap_col, cap_col_n;
    logic [3:0]    r_n, c_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic          kv_n, kh_n;
    logic          onehot, cap_hit;

    assign cs      = ~sync2;
    assign onehot  = (cs != 4'd0) && ((cs & (cs - 4'd1)) == 4'd0);
    assign cap_hit = |(cs & cap_col);
    assign row_drv = ~(4'b1000 >> idx);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1     <= 4'hf;
            sync2     <= 4'hf;
            state     <= SCAN;
            idx       <= 2'd0;
            cap_row   <= 2'd0;
            cap_col   <= 4'd0;
            scnt      <= '0;
            dcnt      <= '0;
            r         <= 4'd0;
            c         <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            sync1     <= col_in;
            sync2     <= sync1;
            state     <= state_n;
            idx       <= idx_n;
            cap_row   <= cap_row_n;
            cap_col   <= cap_col_n;
            scnt      <= scnt_n;
            dcnt      <= dcnt_n;
            r         <= r_n;
            c         <= c_n;
            key_valid <= kv_n;
            key_held  <= kh_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cap_row_n = cap_row;
        cap_col_n = cap_col;
        scnt_n    = scnt;
        dcnt_n    = dcnt;
        r_n       = r;
        c_n       = c;
        kv_n      = 1'b0;
        kh_n      = key_held;
        unique case (state)
            SCAN: begin
                kh_n = 1'b0;
                if (scnt == SCAN_LAST) begin
                    scnt_n = '0;
                    // several columns at once is ambiguous; keep scanning
                    if (onehot) begin
                        state_n   = DEB_PRESS;
                        cap_row_n = idx;
                        cap_col_n = cs;
                        dcnt_n    = '0;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (cs != cap_col) begin
                    state_n = SCAN;
                    idx_n   = idx + 2'd1;
                    scnt_n  = '0;
                    dcnt_n  = '0;
                end else if (dcnt == DEB_LAST) begin
                    state_n = HELD;
                    dcnt_n  = '0;
                    r_n     = 4'b1000 >> cap_row;
                    c_n     = cap_col;
                    kv_n    = 1'b1;
                    kh_n    = 1'b1;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            HELD: begin
                kh_n = 1'b1;
                if (!cap_hit) begin
                    state_n = DEB_REL;
                    dcnt_n  = '0;
                end
            end
            DEB_REL: begin
                if (cap_hit) begin
                    state_n = HELD;
                    dcnt_n  = '0;
                end else if (dcnt == DEB_LAST) begin
                    state_n = SCAN;
                    kh_n    = 1'b0;
                    idx_n   = idx + 2'd1;
                    scnt_n  = '0;
                    dcnt_n  = '0;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

endmodule
